// File: rtl/step_counter.sv
// ----------------------------------------------------------------------------
// step_counter
//   Up/down counter that moves by a fixed STEP each enabled cycle. When a step
//   runs past either end of the WIDTH-bit range, the counter either wraps
//   modulo 2^WIDTH (sat_mode=0) or clamps at the limit (sat_mode=1). A
//   one-cycle flag reports which of the two happened on the previous step.
//
// Parameters
//   WIDTH : counter/data width in bits (2..32)
//   STEP  : step magnitude (1..2^WIDTH-1)
//   INIT  : value taken by cnt_o while reset_n is low
//
// Ports
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   en       : step enable
//   up_dn    : 1 = count up, 0 = count down
//   sat_mode : 0 = wrap on overflow, 1 = saturate on overflow
//   load     : synchronous load strobe (wins over en)
//   load_val : value loaded when load is high
//   cnt_o    : registered count
//   wrap_o   : registered pulse, previous step wrapped
//   sat_o    : registered pulse, previous step was clamped
// ----------------------------------------------------------------------------
module step_counter #(
    parameter int          WIDTH = 8,
    parameter logic [31:0] STEP  = 32'd2,
    parameter logic [31:0] INIT  = 32'd1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o,
    output logic             sat_o
);

    localparam logic [WIDTH-1:0] STEP_W   = STEP[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_W   = INIT[WIDTH-1:0];
    localparam logic [WIDTH:0]   STEP_EXT = {1'b0, STEP_W};
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_MIN  = '0;

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic             r_sat;

    // One extra bit on top of the count: bit WIDTH of the sum is the carry,
    // bit WIDTH of the difference is the borrow (operand zero-extended).
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_over;
    logic [WIDTH-1:0] w_stepped;
    logic [WIDTH-1:0] w_limit;

    logic [WIDTH-1:0] w_cnt_next;
    logic             w_wrap_next;
    logic             w_sat_next;

    assign w_sum     = {1'b0, r_cnt} + STEP_EXT;
    assign w_diff    = {1'b0, r_cnt} - STEP_EXT;
    assign w_over    = up_dn ? w_sum[WIDTH] : w_diff[WIDTH];
    assign w_stepped = up_dn ? w_sum[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_limit   = up_dn ? CNT_MAX : CNT_MIN;

    always_comb begin
        w_cnt_next  = r_cnt;
        w_wrap_next = 1'b0;
        w_sat_next  = 1'b0;
        if (load) begin
            w_cnt_next = load_val;
        end else if (en) begin
            if (!w_over) begin
                w_cnt_next = w_stepped;
            end else if (sat_mode) begin
                // Clamp; stays asserted every cycle the limit is pushed on.
                w_cnt_next = w_limit;
                w_sat_next = 1'b1;
            end else begin
                // Low WIDTH bits of the wide result are already mod 2^WIDTH.
                w_cnt_next  = w_stepped;
                w_wrap_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= INIT_W;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_wrap <= w_wrap_next;
            r_sat  <= w_sat_next;
        end
    end

    assign cnt_o  = r_cnt;
    assign wrap_o = r_wrap;
    assign sat_o  = r_sat;

endmodule

// File: tb/tb_step_counter.sv
// ----------------------------------------------------------------------------
// tb_step_counter
//   Self-checking bench for step_counter: default-parameter instance driven
//   from a vector table, hand sequences for the long count, async reset and
//   randomized traffic against an integer reference model; plus a WIDTH=4,
//   STEP=3, INIT=0 instance for the small-range wrap/saturate sequence.
// ----------------------------------------------------------------------------
module tb_step_counter;

    logic       clk;
    logic       reset_n;
    logic       en, up_dn, sat_mode, load;
    logic [7:0] load_val;
    logic [7:0] cnt_o;
    logic       wrap_o, sat_o;

    logic       en4, up_dn4, sat_mode4, load4;
    logic [3:0] load_val4;
    logic [3:0] cnt4;
    logic       wrap4, sat4;

    int checks   = 0;
    int failures = 0;

    step_counter dut (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn),
        .sat_mode(sat_mode), .load(load), .load_val(load_val),
        .cnt_o(cnt_o), .wrap_o(wrap_o), .sat_o(sat_o)
    );

    step_counter #(.WIDTH(4), .STEP(32'd3), .INIT(32'd0)) dut4 (
        .clk(clk), .reset_n(reset_n), .en(en4), .up_dn(up_dn4),
        .sat_mode(sat_mode4), .load(load4), .load_val(load_val4),
        .cnt_o(cnt4), .wrap_o(wrap4), .sat_o(sat4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic       ud;
        logic       sm;
        logic [7:0] ec;
        logic       ew;
        logic       es;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive the default instance, take one rising edge, sample 1 time unit later.
    task automatic step(input logic ld, input logic [7:0] lv, input logic e,
                        input logic ud, input logic sm);
        load = ld; load_val = lv; en = e; up_dn = ud; sat_mode = sm;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic e, input logic ud, input logic sm);
        load4 = 1'b0; load_val4 = 4'd0; en4 = e; up_dn4 = ud; sat_mode4 = sm;
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed mid-cycle, released mid-cycle, inputs idle.
    task automatic do_reset();
        load = 0; en = 0; up_dn = 1; sat_mode = 0; load_val = 0;
        load4 = 0; en4 = 0; up_dn4 = 1; sat_mode4 = 0; load_val4 = 0;
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    // Reference: plain integer arithmetic on the counter's numeric range.
    function automatic void model(input int w, input int stp, input int cur,
                                  input bit ld, input int lv, input bit e,
                                  input bit ud, input bit sm,
                                  output int nxt, output bit nw, output bit ns);
        int top;
        int raw;
        top = (1 << w) - 1;
        nw = 0; ns = 0; nxt = cur;
        if (ld) begin
            nxt = lv;
        end else if (e) begin
            raw = ud ? cur + stp : cur - stp;
            if (raw > top) begin
                if (sm) begin nxt = top; ns = 1; end
                else begin nxt = raw - (top + 1); nw = 1; end
            end else if (raw < 0) begin
                if (sm) begin nxt = 0; ns = 1; end
                else begin nxt = raw + (top + 1); nw = 1; end
            end else begin
                nxt = raw;
            end
        end
    endfunction

    initial begin
        int m_cnt;
        int m_nxt;
        bit m_w, m_s;
        int e4[12];
        bit w4[12];
        bit s4[12];
        logic r_ld, r_en, r_ud, r_sm;
        logic [7:0] r_lv;

        // ld, lv, en, ud, sm, exp cnt, exp wrap, exp sat   (start: cnt=1)
        vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'hA0, 1'b1, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'hFD, 1'b0, 1'b1, 1'b0, 8'hFD, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h0B, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0};

        e4 = '{3, 6, 9, 12, 15, 2, 5, 8, 11, 14, 15, 15};
        w4 = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        s4 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

        reset_n = 1'b1;
        do_reset();
        chk("reset_cnt", int'(cnt_o), 1);
        chk("reset_wrap", int'(wrap_o), 0);
        chk("reset_sat", int'(sat_o), 0);
        chk("reset4_cnt", int'(cnt4), 0);

        // Vector table
        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ud, vecs[i].sm);
            $display("vec %0d: ld=%0d lv=%02h en=%0d ud=%0d sm=%0d -> cnt=%02h w=%0d s=%0d",
                     i, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ud, vecs[i].sm,
                     cnt_o, wrap_o, sat_o);
            chk($sformatf("vec%0d_cnt", i), int'(cnt_o), int'(vecs[i].ec));
            chk($sformatf("vec%0d_wrap", i), int'(wrap_o), int'(vecs[i].ew));
            chk($sformatf("vec%0d_sat", i), int'(sat_o), int'(vecs[i].es));
        end
        // Landing exactly on 0 going down must not flag
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("land0_cnt", int'(cnt_o), 0);
        chk("land0_sat", int'(sat_o), 0);

        // Full up-count from reset: 3..255 over 127 edges, then wrap to 1
        do_reset();
        for (int i = 1; i <= 127; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
            chk("upcnt_cnt", int'(cnt_o), 1 + 2 * i);
            chk("upcnt_wrap", int'(wrap_o), 0);
        end
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        $display("upcount edge 128: cnt=%02h wrap=%0d", cnt_o, wrap_o);
        chk("upcnt128_cnt", int'(cnt_o), 1);
        chk("upcnt128_wrap", int'(wrap_o), 1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("upcnt129_cnt", int'(cnt_o), 3);
        chk("upcnt129_wrap", int'(wrap_o), 0);

        // Asynchronous reset mid-count
        step(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_cnt", int'(cnt_o), 8'h41);
        en = 1'b1; load = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        $display("async reset: cnt=%02h", cnt_o);
        chk("async_rst_cnt", int'(cnt_o), 1);
        load = 1'b1; load_val = 8'h77;
        @(posedge clk);
        #1;
        chk("rst_hold_cnt", int'(cnt_o), 1);
        chk("rst_hold_wrap", int'(wrap_o), 0);
        #2;
        reset_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("post_rst_cnt", int'(cnt_o), 3);

        // WIDTH=4, STEP=3, INIT=0 instance
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step4(1'b1, 1'b1, (i >= 10) ? 1'b1 : 1'b0);
            $display("w4 step %0d: cnt=%0d w=%0d s=%0d", i, cnt4, wrap4, sat4);
            chk("w4_cnt", int'(cnt4), e4[i]);
            chk("w4_wrap", int'(wrap4), int'(w4[i]));
            chk("w4_sat", int'(sat4), int'(s4[i]));
        end

        // Randomized traffic against the reference model
        do_reset();
        m_cnt = 1;
        for (int i = 0; i < 400; i++) begin
            r_ld = ($urandom_range(0, 9) == 0);
            r_en = ($urandom_range(0, 4) != 0);
            r_ud = 1'(($urandom));
            r_sm = 1'(($urandom));
            r_lv = 8'($urandom);
            if ($urandom_range(0, 7) == 0) r_lv = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            model(8, 2, m_cnt, r_ld, int'(r_lv), r_en, r_ud, r_sm, m_nxt, m_w, m_s);
            step(r_ld, r_lv, r_en, r_ud, r_sm);
            chk("rand_cnt", int'(cnt_o), m_nxt);
            chk("rand_wrap", int'(wrap_o), int'(m_w));
            chk("rand_sat", int'(sat_o), int'(m_s));
            if (wrap_o && sat_o) chk("rand_excl", 1, 0);
            m_cnt = m_nxt;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_counter.md
STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter and data width in bits (legal range 2..32).
REQ-002 Parameter STEP, default 2, increment/decrement magnitude (legal range 1..2^WIDTH-1).
REQ-003 Parameter INIT, default 1, value loaded into cnt_o on reset (legal range 0..2^WIDTH-1).
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-005 reset_n  input  1  reset SHALL be asynchronous and active-low.
REQ-006 en  input  1  count enable; when high, counter SHALL step once per cycle.
REQ-007 up_dn  input  1  direction; 1 = count up by STEP, 0 = count down by STEP.
REQ-008 sat_mode  input  1  overflow policy; 0 = wrap modulo 2^WIDTH, 1 = saturate.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  WIDTH  value written to counter when load is high.
REQ-011 cnt_o  output  WIDTH  registered count value.
REQ-012 wrap_o  output  1  registered one-cycle pulse: previous step wrapped (sat_mode=0).
REQ-013 sat_o  output  1  registered one-cycle pulse: previous step clamped (sat_mode=1).

Function
REQ-014 Per-cycle priority SHALL be: load > en > hold.
REQ-015 load=1: cnt_o <= load_val next edge; wrap_o <= 0; sat_o <= 0; en, up_dn ignored.
REQ-016 load=0, en=0: cnt_o SHALL hold; wrap_o and sat_o SHALL be 0 next cycle.
REQ-017 Step arithmetic SHALL use a WIDTH+1-bit intermediate to detect carry (up) or borrow (down).
REQ-018 Up, no carry: cnt_o <= cnt_o + STEP; wrap_o <= 0; sat_o <= 0.
REQ-019 Up, carry, sat_mode=0: cnt_o <= (cnt_o + STEP) mod 2^WIDTH; wrap_o <= 1.
REQ-020 Up, carry, sat_mode=1: cnt_o <= 2^WIDTH-1; sat_o <= 1.
REQ-021 Down, no borrow: cnt_o <= cnt_o - STEP; flags 0.
REQ-022 Down, borrow, sat_mode=0: cnt_o <= (cnt_o - STEP) mod 2^WIDTH; wrap_o <= 1.
REQ-023 Down, borrow, sat_mode=1: cnt_o <= 0; sat_o <= 1.
REQ-024 Landing exactly on 2^WIDTH-1 (up) or 0 (down) without carry/borrow SHALL NOT assert wrap_o or sat_o.
REQ-025 Holding at a saturated limit with en=1 SHALL re-assert sat_o every cycle the step would still overflow.
REQ-026 wrap_o and sat_o SHALL never be high in the same cycle.
REQ-027 up_dn and sat_mode SHALL be sampled each cycle; changes take effect on the next stepping edge, no extra latency.
REQ-028 Latency from any input to cnt_o/flags SHALL be exactly one clock edge; no combinational input-to-output path.

Reset
REQ-029 reset_n low SHALL immediately, without a clock, force cnt_o = INIT, wrap_o = 0, sat_o = 0.
REQ-030 While reset_n is low, load and en SHALL be ignored.
REQ-031 After reset_n deassertion, first step SHALL occur on the first rising edge with reset_n high and en or load high.
REQ-032 Reset asserted mid-count SHALL abandon the in-progress value; no partial update on the deassertion edge.

Verification
REQ-033 Defaults (WIDTH=8, STEP=2, INIT=1), reset then en=1, up_dn=1, sat_mode=0 -> cnt_o 1,3,5,...,255 over 127 edges; 128th edge cnt_o=1, wrap_o=1 for one cycle.
REQ-034 Defaults, load_val=0x05, up_dn=0, sat_mode=1, en=1 -> cnt_o 5,3,1,0 (sat_o=1), then 0 with sat_o=1 each further cycle.
REQ-035 Defaults, cnt_o=0x11, load=1 with load_val=0xA0 and en=1 same cycle -> cnt_o=0xA0, no step applied, flags 0.
REQ-036 Defaults, counting up at cnt_o=0x41, reset_n pulsed low mid-cycle -> cnt_o=0x01 before next clock edge; first edge after release with en=1 -> 0x03.
REQ-037 WIDTH=4, STEP=3, INIT=0, sat_mode=0, up -> 0,3,6,9,12,15,2 (wrap_o=1 at 2); switch sat_mode=1 at 14 -> 15 (sat_o=1), then 15 with sat_o=1.
REQ-038 Defaults, en toggled 1,0,0,1 from cnt_o=0x07 -> 0x09, 0x09, 0x09, 0x0B; flags 0 throughout.
